// File: rtl/jelly2_video_overlay_blend_core.sv
// Sprite overlay core: frame-latched window parameters, per-pixel
// coordinate tracking, sprite memory read with configurable latency,
// and alpha/opaque blend onto an AXI4-Stream video stream.
module jelly2_video_overlay_blend_core #(
  parameter int TUSER_WIDTH     = 1,
  parameter int COMPONENTS      = 3,
  parameter int COMPONENT_WIDTH = 8,
  parameter int ALPHA_WIDTH     = 8,
  parameter int IMG_X_WIDTH     = 12,
  parameter int IMG_Y_WIDTH     = 12,
  parameter int MEM_X_WIDTH     = 8,
  parameter int MEM_Y_WIDTH     = 7,
  parameter int MEM_LATENCY     = 1,
  localparam int TDATA_WIDTH    = COMPONENTS * COMPONENT_WIDTH,
  localparam int MEM_DATA_WIDTH = ALPHA_WIDTH + TDATA_WIDTH
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       aclken,

  input  logic                       enable,
  input  logic [IMG_X_WIDTH-1:0]     param_x,
  input  logic [IMG_Y_WIDTH-1:0]     param_y,
  input  logic [IMG_X_WIDTH-1:0]     param_width,
  input  logic [IMG_Y_WIDTH-1:0]     param_height,
  input  logic [1:0]                 param_scale_x,
  input  logic [1:0]                 param_scale_y,
  input  logic                       param_alpha_en,

  output logic                       mem_en,
  output logic [MEM_X_WIDTH-1:0]     mem_addrx,
  output logic [MEM_Y_WIDTH-1:0]     mem_addry,
  input  logic [MEM_DATA_WIDTH-1:0]  mem_dout,

  input  logic [TUSER_WIDTH-1:0]     s_axi4s_tuser,
  input  logic                       s_axi4s_tlast,
  input  logic [TDATA_WIDTH-1:0]     s_axi4s_tdata,
  input  logic                       s_axi4s_tvalid,
  output logic                       s_axi4s_tready,

  output logic [TUSER_WIDTH-1:0]     m_axi4s_tuser,
  output logic                       m_axi4s_tlast,
  output logic [TDATA_WIDTH-1:0]     m_axi4s_tdata,
  output logic                       m_axi4s_tvalid,
  input  logic                       m_axi4s_tready
);

  localparam int L  = MEM_LATENCY;
  localparam int PW = COMPONENT_WIDTH + ALPHA_WIDTH + 2;
  localparam logic [ALPHA_WIDTH:0] A_ONE = {1'b1, {ALPHA_WIDTH{1'b0}}};

  logic cke;
  logic acc;
  logic fs;

  assign cke            = aclken && (!m_axi4s_tvalid || m_axi4s_tready);
  assign s_axi4s_tready = cke;
  assign mem_en         = cke;
  assign acc            = s_axi4s_tvalid && cke;
  assign fs             = s_axi4s_tuser[0];

  // frame-latched parameter shadows
  logic                   sh_en;
  logic [IMG_X_WIDTH-1:0] sh_x;
  logic [IMG_Y_WIDTH-1:0] sh_y;
  logic [IMG_X_WIDTH-1:0] sh_w;
  logic [IMG_Y_WIDTH-1:0] sh_h;
  logic [1:0]             sh_sx;
  logic [1:0]             sh_sy;
  logic                   sh_aen;

  // effective parameters for the current beat
  logic                   ef_en;
  logic [IMG_X_WIDTH-1:0] ef_x;
  logic [IMG_Y_WIDTH-1:0] ef_y;
  logic [IMG_X_WIDTH-1:0] ef_w;
  logic [IMG_Y_WIDTH-1:0] ef_h;
  logic [1:0]             ef_sx;
  logic [1:0]             ef_sy;
  logic                   ef_aen;

  logic [IMG_X_WIDTH-1:0] cnt_x;
  logic [IMG_Y_WIDTH-1:0] cnt_y;
  logic [IMG_X_WIDTH-1:0] pix_x;
  logic [IMG_Y_WIDTH-1:0] pix_y;
  logic [IMG_X_WIDTH:0]   x_end;
  logic [IMG_Y_WIDTH:0]   y_end;
  logic [IMG_X_WIDTH-1:0] off_x;
  logic [IMG_Y_WIDTH-1:0] off_y;
  logic                   hit;
  logic [MEM_X_WIDTH-1:0] addr_x;
  logic [MEM_Y_WIDTH-1:0] addr_y;

  // pipeline: index 0 is the coordinate/address stage, 1..L follow the memory read
  logic                   st_valid [0:L];
  logic [TUSER_WIDTH-1:0] st_user  [0:L];
  logic                   st_last  [0:L];
  logic                   st_hit   [0:L];
  logic                   st_aen   [0:L];
  logic [TDATA_WIDTH-1:0] st_data  [0:L];

  logic [ALPHA_WIDTH-1:0] a_raw;
  logic [ALPHA_WIDTH:0]   a_w;
  logic [ALPHA_WIDTH:0]   a_inv;
  logic [PW-1:0]          prod;
  logic [TDATA_WIDTH-1:0] blend;

  // latch window parameters on the frame-start beat
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sh_en  <= 1'b0;
      sh_x   <= '0;
      sh_y   <= '0;
      sh_w   <= '0;
      sh_h   <= '0;
      sh_sx  <= '0;
      sh_sy  <= '0;
      sh_aen <= 1'b0;
    end else if (acc && fs) begin
      sh_en  <= enable;
      sh_x   <= param_x;
      sh_y   <= param_y;
      sh_w   <= param_width;
      sh_h   <= param_height;
      sh_sx  <= param_scale_x;
      sh_sy  <= param_scale_y;
      sh_aen <= param_alpha_en;
    end
  end

  // frame-start beat bypasses the shadows; compute coordinate, hit and address
  always_comb begin
    ef_en  = fs ? enable         : sh_en;
    ef_x   = fs ? param_x        : sh_x;
    ef_y   = fs ? param_y        : sh_y;
    ef_w   = fs ? param_width    : sh_w;
    ef_h   = fs ? param_height   : sh_h;
    ef_sx  = fs ? param_scale_x  : sh_sx;
    ef_sy  = fs ? param_scale_y  : sh_sy;
    ef_aen = fs ? param_alpha_en : sh_aen;
    pix_x  = fs ? '0 : cnt_x;
    pix_y  = fs ? '0 : cnt_y;
    x_end  = {1'b0, ef_x} + {1'b0, ef_w};
    y_end  = {1'b0, ef_y} + {1'b0, ef_h};
    hit    = ef_en
          && (pix_x >= ef_x) && ({1'b0, pix_x} < x_end)
          && (pix_y >= ef_y) && ({1'b0, pix_y} < y_end);
    off_x  = pix_x - ef_x;
    off_y  = pix_y - ef_y;
    addr_x = MEM_X_WIDTH'(off_x >> ef_sx);
    addr_y = MEM_Y_WIDTH'(off_y >> ef_sy);
  end

  // pixel counters advance on every accepted beat
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_x <= '0;
      cnt_y <= '0;
    end else if (acc) begin
      if (s_axi4s_tlast) begin
        cnt_x <= '0;
        cnt_y <= pix_y + IMG_Y_WIDTH'(1);
      end else begin
        cnt_x <= pix_x + IMG_X_WIDTH'(1);
        cnt_y <= pix_y;
      end
    end
  end

  // stage 0 plus delay line matching the memory read latency
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i <= L; i++) begin
        st_valid[i] <= 1'b0;
        st_user[i]  <= '0;
        st_last[i]  <= 1'b0;
        st_hit[i]   <= 1'b0;
        st_aen[i]   <= 1'b0;
        st_data[i]  <= '0;
      end
      mem_addrx <= '0;
      mem_addry <= '0;
    end else if (cke) begin
      st_valid[0] <= s_axi4s_tvalid;
      st_user[0]  <= s_axi4s_tuser;
      st_last[0]  <= s_axi4s_tlast;
      st_hit[0]   <= hit;
      st_aen[0]   <= ef_aen;
      st_data[0]  <= s_axi4s_tdata;
      mem_addrx   <= addr_x;
      mem_addry   <= addr_y;
      for (int unsigned i = 1; i <= L; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_user[i]  <= st_user[i-1];
        st_last[i]  <= st_last[i-1];
        st_hit[i]   <= st_hit[i-1];
        st_aen[i]   <= st_aen[i-1];
        st_data[i]  <= st_data[i-1];
      end
    end
  end

  // alpha blend of the sprite word over the delayed input pixel
  always_comb begin
    a_raw = mem_dout[MEM_DATA_WIDTH-1 -: ALPHA_WIDTH];
    a_w   = {1'b0, a_raw} + (ALPHA_WIDTH+1)'(a_raw >> (ALPHA_WIDTH-1));
    if (!st_aen[L]) begin
      a_w = A_ONE;
    end
    a_inv = A_ONE - a_w;
    prod  = '0;
    blend = st_data[L];
    if (st_hit[L]) begin
      for (int unsigned c = 0; c < COMPONENTS; c++) begin
        prod = PW'(mem_dout[c*COMPONENT_WIDTH +: COMPONENT_WIDTH]) * PW'(a_w)
             + PW'(st_data[L][c*COMPONENT_WIDTH +: COMPONENT_WIDTH]) * PW'(a_inv);
        blend[c*COMPONENT_WIDTH +: COMPONENT_WIDTH] = COMPONENT_WIDTH'(prod >> ALPHA_WIDTH);
      end
    end
  end

  // output register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axi4s_tvalid <= 1'b0;
      m_axi4s_tuser  <= '0;
      m_axi4s_tlast  <= 1'b0;
      m_axi4s_tdata  <= '0;
    end else if (cke) begin
      m_axi4s_tvalid <= st_valid[L];
      m_axi4s_tuser  <= st_user[L];
      m_axi4s_tlast  <= st_last[L];
      m_axi4s_tdata  <= blend;
    end
  end

endmodule

// File: tb/tb_jelly2_video_overlay_blend_core.sv
// Bench for the overlay blend core: two instances (memory latency 1 and 3)
// share one beat stream; a pixel-level reference model feeds per-instance
// scoreboards that a monitor drains on each output handshake.
module tb_jelly2_video_overlay_blend_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn, aclken, enable, param_alpha_en;
  logic [11:0] param_x, param_y, param_width, param_height;
  logic [1:0]  param_scale_x, param_scale_y;
  logic [0:0]  s_tuser;
  logic        s_tlast;
  logic [23:0] s_tdata;
  logic        sv1, sv3, sr1, sr3;
  logic        m_tready;
  logic [0:0]  mu1, mu3;
  logic        ml1, ml3, mv1, mv3;
  logic [23:0] md1, md3;
  logic        men1, men3;
  logic [7:0]  max1, max3;
  logic [6:0]  may1, may3;
  logic [31:0] mdo1, mdo3;

  jelly2_video_overlay_blend_core #(.MEM_LATENCY(1)) u_dut1 (
    .aclk(clk), .aresetn(aresetn), .aclken(aclken), .enable(enable),
    .param_x(param_x), .param_y(param_y), .param_width(param_width), .param_height(param_height),
    .param_scale_x(param_scale_x), .param_scale_y(param_scale_y), .param_alpha_en(param_alpha_en),
    .mem_en(men1), .mem_addrx(max1), .mem_addry(may1), .mem_dout(mdo1),
    .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tdata(s_tdata),
    .s_axi4s_tvalid(sv1), .s_axi4s_tready(sr1),
    .m_axi4s_tuser(mu1), .m_axi4s_tlast(ml1), .m_axi4s_tdata(md1),
    .m_axi4s_tvalid(mv1), .m_axi4s_tready(m_tready)
  );

  jelly2_video_overlay_blend_core #(.MEM_LATENCY(3)) u_dut3 (
    .aclk(clk), .aresetn(aresetn), .aclken(aclken), .enable(enable),
    .param_x(param_x), .param_y(param_y), .param_width(param_width), .param_height(param_height),
    .param_scale_x(param_scale_x), .param_scale_y(param_scale_y), .param_alpha_en(param_alpha_en),
    .mem_en(men3), .mem_addrx(max3), .mem_addry(may3), .mem_dout(mdo3),
    .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tdata(s_tdata),
    .s_axi4s_tvalid(sv3), .s_axi4s_tready(sr3),
    .m_axi4s_tuser(mu3), .m_axi4s_tlast(ml3), .m_axi4s_tdata(md3),
    .m_axi4s_tvalid(mv3), .m_axi4s_tready(m_tready)
  );

  // sprite memory with per-instance read pipelines that hold while disabled
  logic [31:0] mem [0:127][0:255];
  logic [31:0] rd1;
  logic [31:0] rd3 [0:2];
  always @(posedge clk) if (men1) rd1 <= mem[may1][max1];
  always @(posedge clk) if (men3) begin
    rd3[0] <= mem[may3][max3];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign mdo1 = rd1;
  assign mdo3 = rd3[2];

  typedef struct {
    logic        user;
    logic        last;
    logic [23:0] data;
    time         t;
    bit          lat;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   stall = 0;
  bit   data_rand = 0;

  // reference model state: pixel position and latched parameters
  int mx, my, sh_x, sh_y, sh_w, sh_h, sh_sx, sh_sy;
  bit sh_en, sh_aen;

  task automatic model_reset();
    mx = 0; my = 0; sh_x = 0; sh_y = 0; sh_w = 0; sh_h = 0;
    sh_sx = 0; sh_sy = 0; sh_en = 0; sh_aen = 0;
  endtask

  task automatic model_beat(input bit user, input bit last, input logic [23:0] din,
                            output logic [23:0] dout);
    int x, y, ax, ay, a, ov, iv;
    logic [31:0] w;
    if (user) begin
      mx = 0; my = 0;
      sh_en = enable; sh_aen = param_alpha_en;
      sh_x = int'(param_x); sh_y = int'(param_y);
      sh_w = int'(param_width); sh_h = int'(param_height);
      sh_sx = int'(param_scale_x); sh_sy = int'(param_scale_y);
    end
    x = mx; y = my;
    dout = din;
    if (sh_en && x >= sh_x && x < sh_x + sh_w && y >= sh_y && y < sh_y + sh_h) begin
      ax = ((x - sh_x) >> sh_sx) % 256;
      ay = ((y - sh_y) >> sh_sy) % 128;
      w  = mem[ay][ax];
      a  = sh_aen ? int'(w[31:24]) + int'(w[31:24]) / 128 : 256;
      for (int c = 0; c < 3; c++) begin
        ov = int'(w[c*8 +: 8]);
        iv = int'(din[c*8 +: 8]);
        dout[c*8 +: 8] = 8'((ov * a + iv * (256 - a)) / 256);
      end
    end
    if (last) begin mx = 0; my = (y + 1) % 4096; end
    else mx = (x + 1) % 4096;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // fill: 0 = address pattern with random alpha, 1 = white with stepped alpha, 2 = random
  task automatic fill_mem(input int mode);
    for (int y = 0; y < 128; y++) begin
      for (int x = 0; x < 256; x++) begin
        case (mode)
          0: mem[y][x] = {8'($urandom), 8'(x), 8'(y), 8'(x ^ y)};
          1: mem[y][x] = {(x % 4 == 0) ? 8'd255 : (x % 4 == 1) ? 8'd128 :
                          (x % 4 == 2) ? 8'd0 : 8'($urandom), 24'hFFFFFF};
          default: mem[y][x] = $urandom;
        endcase
      end
    end
  endtask

  task automatic set_params(input bit en, input int px, input int py, input int pw, input int ph,
                            input int sx, input int sy, input bit aen);
    enable = en; param_x = 12'(px); param_y = 12'(py);
    param_width = 12'(pw); param_height = 12'(ph);
    param_scale_x = 2'(sx); param_scale_y = 2'(sy); param_alpha_en = aen;
  endtask

  // called at a negedge; returns at a negedge once both instances accepted
  task automatic send_beat(input bit user, input bit last, input logic [23:0] d);
    exp_t e;
    bit p1, p3;
    int n;
    if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
    model_beat(user, last, d, e.data);
    e.user = user; e.last = last; e.lat = !stall; e.t = 0;
    s_tuser = user; s_tlast = last; s_tdata = d;
    sv1 = 1'b1; sv3 = 1'b1; p1 = 1'b1; p3 = 1'b1; n = 0;
    while (p1 || p3) begin
      #3;
      if (p1 && sr1) begin e.t = $time; q1.push_back(e); p1 = 1'b0; end
      if (p3 && sr3) begin e.t = $time; q3.push_back(e); p3 = 1'b0; end
      @(negedge clk);
      sv1 = p1; sv3 = p3;
      n++;
      if (n > 200 && (p1 || p3)) begin
        vectors++; miscompares++;
        $display("FAIL input_accept: got no tready after %0d cycles, required acceptance", n);
        p1 = 1'b0; p3 = 1'b0; sv1 = 1'b0; sv3 = 1'b0;
      end
    end
  endtask

  task automatic send_frame(input int w, input int h, input int trunc,
                            input int mid_at, input int mid_px);
    logic [23:0] d;
    for (int i = 0; i < w * h; i++) begin
      if (trunc > 0 && i == trunc) break;
      if (i == mid_at) param_x = 12'(mid_px);
      d = data_rand ? 24'($urandom) : 24'(i);
      send_beat(i == 0, (i % w) == w - 1, d);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q3.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (q1.size() != 0 || q3.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d outstanding, required 0/0", q1.size(), q3.size());
    end
  endtask

  task automatic mon_check(input int lat, input logic u, input logic l, input logic [23:0] d);
    exp_t e;
    vectors++;
    if ((lat == 1 && q1.size() == 0) || (lat == 3 && q3.size() == 0)) begin
      miscompares++;
      $display("FAIL out_L%0d: got unexpected beat d=%06h, required none", lat, d);
    end else begin
      e = (lat == 1) ? q1.pop_front() : q3.pop_front();
      if ({u, l, d} !== {e.user, e.last, e.data}) begin
        miscompares++;
        $display("FAIL out_L%0d: got u=%0b l=%0b d=%06h, required u=%0b l=%0b d=%06h",
                 lat, u, l, d, e.user, e.last, e.data);
      end
      if (e.lat) begin
        vectors++;
        if (($time - e.t) != time'((lat + 2) * 10)) begin
          miscompares++;
          $display("FAIL latency_L%0d: got %0t required %0d", lat, $time - e.t, (lat + 2) * 10);
        end
      end
    end
  endtask

  // output monitor: a handshake completes at the posedge following this sample
  always @(negedge clk) begin
    #3;
    if (aresetn === 1'b1 && aclken && m_tready) begin
      if (mv1) mon_check(1, mu1[0], ml1, md1);
      if (mv3) mon_check(3, mu3[0], ml3, md3);
    end
  end

  // downstream readiness and clock enable
  initial begin
    m_tready = 1'b1;
    aclken   = 1'b1;
    forever begin
      @(negedge clk);
      if (stall) begin
        m_tready = ($urandom % 4) != 0;
        aclken   = ($urandom % 8) != 0;
      end else begin
        m_tready = 1'b1;
        aclken   = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b1;
    sv1 = 1'b0; sv3 = 1'b0;
    s_tuser = '0; s_tlast = 1'b0; s_tdata = '0;
    set_params(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    fill_mem(0);
    #2 aresetn = 1'b0;
    #10;
    chk("rst_tvalid",  {31'd0, mv1} | {31'd0, mv3}, 32'd0);
    chk("rst_tuser",   {31'd0, mu1} | {31'd0, mu3}, 32'd0);
    chk("rst_tlast",   {31'd0, ml1} | {31'd0, ml3}, 32'd0);
    chk("rst_tdata",   {8'd0, md1 | md3}, 32'd0);
    chk("rst_addr",    {17'd0, may1 | may3, max1 | max3}, 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);

    // passthrough, index data
    set_params(0, 2, 1, 5, 2, 0, 0, 0);
    send_frame(16, 4, 0, -1, 0);
    drain();

    // opaque window
    fill_mem(0);
    set_params(1, 4, 1, 4, 2, 0, 0, 0);
    send_frame(16, 4, 0, -1, 0);
    drain();

    // alpha over black: 255 / 128 / 0 / random
    fill_mem(1);
    set_params(1, 0, 0, 8, 2, 0, 0, 1);
    s_tdata = '0;
    for (int i = 0; i < 16; i++) send_beat(i == 0, (i % 8) == 7, 24'h000000);
    drain();

    // zoom
    fill_mem(0);
    data_rand = 1;
    set_params(1, 3, 2, 20, 12, 1, 2, 1);
    send_frame(24, 16, 0, -1, 0);
    drain();

    // frame latching and tuser-only restart
    set_params(1, 2, 0, 3, 3, 0, 0, 0);
    send_frame(10, 4, 0, 15, 6);
    send_frame(10, 4, 13, -1, 0);
    send_frame(10, 4, 0, -1, 0);
    drain();

    // random stalls, random parameters
    stall = 1;
    fill_mem(2);
    for (int f = 0; f < 8; f++) begin
      set_params(($urandom % 5) != 0, $urandom_range(0, 15), $urandom_range(0, 4),
                 $urandom_range(0, 12), $urandom_range(0, 4), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom % 2);
      if (f == 5) param_x = 12'd4090;
      send_frame($urandom_range(4, 20), $urandom_range(2, 6), 0, -1, 0);
    end
    drain();

    // reset mid-frame
    set_params(1, 1, 1, 6, 3, 0, 0, 1);
    send_frame(12, 4, 20, -1, 0);
    aresetn = 1'b0;
    #1;
    chk("midrst_tvalid", {30'd0, mv1, mv3}, 32'd0);
    q1.delete();
    q3.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    send_frame(12, 4, 0, -1, 0);
    drain();

    stall = 0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
